// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with variable step, clamped parallel load,
// registered wrap pulse and zero/max decodes.
// Define UPDOWN_CNT_SATURATE_EN to saturate at the range limits instead of wrapping.
module updown_counter_param #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_CNT = 2**WIDTH-1,
  parameter int unsigned STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              hold,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  cnt,
  output logic              wrap,
  output logic              at_zero,
  output logic              at_max
);

  // One bit wider than the widest operand, so sums and the modulus never overflow.
  localparam int unsigned EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  localparam logic [EW-1:0] MAX_X = EW'(MAX_CNT);
  localparam logic [EW-1:0] MOD_X = EW'(MAX_CNT) + EW'(1);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             wrap_reg, wrap_next;

  logic [EW-1:0] cnt_x, step_x, load_x;

  assign cnt_x  = EW'(cnt_reg);
  assign step_x = EW'(step);
  assign load_x = EW'(load_val);

  always_comb begin
    cnt_next  = cnt_reg;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = (load_x > MAX_X) ? WIDTH'(MAX_X) : load_val;
    end else if (ena && !hold) begin
      if (up_down) begin
        if (cnt_x + step_x > MAX_X) begin
          wrap_next = 1'b1;
`ifdef UPDOWN_CNT_SATURATE_EN
          cnt_next  = WIDTH'(MAX_X);
`else
          cnt_next  = WIDTH'(cnt_x + step_x - MOD_X);
`endif
        end else begin
          cnt_next = WIDTH'(cnt_x + step_x);
        end
      end else begin
        if (step_x > cnt_x) begin
          wrap_next = 1'b1;
`ifdef UPDOWN_CNT_SATURATE_EN
          cnt_next  = '0;
`else
          cnt_next  = WIDTH'(cnt_x + MOD_X - step_x);
`endif
        end else begin
          cnt_next = WIDTH'(cnt_x - step_x);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      // A step larger than the range would skip past a full period.
      if (!load && ena && !hold) begin
        assert (step_x <= MAX_X)
          else $error("updown_counter_param: step exceeds MAX_CNT");
      end
      cnt_reg  <= cnt_next;
      wrap_reg <= wrap_next;
    end
  end

  assign cnt     = cnt_reg;
  assign wrap    = wrap_reg;
  assign at_zero = (cnt_reg == '0);
  assign at_max  = (cnt_reg == WIDTH'(MAX_X));

endmodule
